ysyx_24110015_icache: RTL and testbench
=======================================

YSYX_24110015_ICACHE -- requirements
Module: ysyx_24110015_icache

Interface
REQ-001 SHALL provide parameter SETS, default 16: number of direct-mapped lines (power of two, 2..64).
REQ-002 SHALL provide parameter BLOCK_WORDS, default 4: 32-bit words per line (power of two, 1..8).
REQ-003 SHALL provide the following ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  cache can accept a request.
- ifu_addr  in  32  fetch address, word aligned.
- ifu_rsp_valid  out  1  one-cycle response pulse.
- ifu_rdata  out  32  instruction word.
- ifu_rsp_err  out  1  bus error on the fetch.
- fence_i  in  1  invalidate all lines.
- arvalid  out  1  AXI4 read address valid.
- arready  in  1  read address ready.
- araddr  out  32  line-aligned refill address.
- arlen  out  8  burst length minus one.
- arsize  out  3  burst size.
- arburst  out  2  burst type.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.
- rdata  in  32  read data.
- rresp  in  2  read response.
- rlast  in  1  last beat.

Function
REQ-004 SHALL split the address as tag = addr[31:OFF+IDX], index = addr[OFF+IDX-1:OFF], word = addr[OFF-1:2], with OFF = 2+log2(BLOCK_WORDS) and IDX = log2(SETS).
REQ-005 SHALL implement FSM states IDLE, AR, R and RESP.
REQ-006 SHALL hold ifu_req_ready=1 only in IDLE; a request SHALL be accepted when ifu_req_valid && ifu_req_ready, and ifu_addr SHALL be latched on acceptance.
REQ-007 On a hit (valid[index] and tag match), the FSM SHALL go IDLE->RESP; ifu_rsp_valid=1 the cycle after acceptance (1-cycle latency), then return to IDLE.
REQ-008 On a miss, the FSM SHALL go IDLE->AR with the following AR fields:
- araddr = latched address with low OFF bits cleared;
- arlen = BLOCK_WORDS-1;
- arsize = 3'b010;
- arburst = 2'b01 (INCR).
REQ-009 arvalid SHALL stay high in AR until arready; araddr SHALL stay stable while waiting; the FSM SHALL then go AR->R.
REQ-010 In R, rready SHALL be 1, and each rvalid beat SHALL be written to data[index][beat], with the beat counter starting at 0.
REQ-011 On rvalid && rlast, the FSM SHALL go R->RESP and write tag[index].
- valid[index] SHALL be set only if every beat returned rresp==2'b00.
REQ-012 In RESP after a refill, ifu_rdata SHALL be the requested word from the refilled line; ifu_rsp_err=1 if any beat returned rresp!=0, else 0.
REQ-013 An errored refill SHALL leave the line invalid, so the next fetch to it misses again.
REQ-014 ifu_rsp_err SHALL be 0 on every hit response.
REQ-015 fence_i in IDLE SHALL clear all valid bits next cycle and SHALL take priority over a same-cycle request, which is not accepted (ifu_req_ready=0 that cycle).
REQ-016 fence_i in AR, R or RESP SHALL be recorded and applied on return to IDLE, after the in-flight line is installed.
REQ-017 arvalid SHALL be 0 outside AR, and rready SHALL be 0 outside R.
REQ-018 An rlast arriving before BLOCK_WORDS beats SHALL end the refill as an error per REQ-012/REQ-013.

Reset
REQ-019 While rst=1, state SHALL be IDLE, all valid bits SHALL be 0, the beat counter SHALL be 0, any pending fence SHALL be cleared, and the outputs SHALL be:
- ifu_rsp_valid=0, ifu_rsp_err=0, ifu_rdata=0;
- arvalid=0, rready=0, araddr=0;
- ifu_req_ready=0.
REQ-020 Reset asserted mid-refill SHALL abandon the burst; any remaining R beats arriving after reset SHALL be ignored with rready=0.

Configuration
REQ-021 Macro YSYX_24110015_ICACHE_PERF_EN SHALL control the hit/miss counters.
- When defined: add outputs perf_hit  out  32 and perf_miss  out  32, reset to 0, incrementing once per accepted hit/miss and wrapping at 2^32.
- When undefined: these ports and counters SHALL NOT exist, with no other behavioural change.

Verification
REQ-022 Cold fetch 0x3000_0004 with arready=1 and 4 beats rresp=0 -> araddr=0x3000_0000, arlen=3, and ifu_rdata = beat 1.
REQ-023 Repeat fetch 0x3000_0008 -> ifu_rsp_valid the next cycle, no arvalid; with PERF_EN, perf_hit=1 and perf_miss=1.
REQ-024 Fetch 0x3000_0100 (same index, different tag at defaults) -> miss refill; then 0x3000_0000 misses again.
REQ-025 Refill with beat 2 rresp=2'b10 -> ifu_rsp_err=1; the same address then refetches and issues AR again.
REQ-026 fence_i pulsed while in R -> refill completes and the response is delivered; the next fetch to that line misses.
REQ-027 rst asserted during beat 1 -> next cycle all outputs are at reset values; a subsequent fetch to that line misses.

Source files
------------

// File: rtl/ysyx_24110015_icache.sv
// ysyx_24110015_icache: direct-mapped instruction cache with AXI4 INCR burst refill.
// Optional hit/miss performance counters are built when YSYX_24110015_ICACHE_PERF_EN is defined.
module ysyx_24110015_icache #(
  parameter int unsigned SETS        = 16,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_rsp_err,
  input  logic        fence_i,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
`ifdef YSYX_24110015_ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
`endif
);

  localparam int unsigned IDX_W     = $clog2(SETS);
  localparam int unsigned WOFF_W    = $clog2(BLOCK_WORDS);
  localparam int unsigned OFF       = 2 + WOFF_W;
  localparam int unsigned TAG_W     = 32 - OFF - IDX_W;
  localparam int unsigned WRD_W     = (WOFF_W == 0) ? 1 : WOFF_W;
  localparam int unsigned CNT_W     = WOFF_W + 1;
  localparam logic [31:0] LINE_MASK = ~(32'(BLOCK_WORDS * 4) - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tags_q [SETS];
  logic [31:0]        data_q [SETS][BLOCK_WORDS];
  logic [IDX_W-1:0]   idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WRD_W-1:0]   word_q;
  logic [CNT_W-1:0]   beat_q;
  logic               fence_pend_q;
  logic [31:0]        araddr_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic [IDX_W-1:0]   req_idx_c;
  logic [TAG_W-1:0]   req_tag_c;
  logic [WRD_W-1:0]   req_word_c;
  logic [WRD_W-1:0]   beat_word_c;
  logic               hit_c;
  logic               accept_c;
  logic               beat_fire_c;
  logic               beat_ok_c;
  logic               beat_err_c;
  logic               fence_now_c;

  // Address decomposition of the incoming fetch and lookup against the tag store.
  assign req_idx_c   = IDX_W'(ifu_addr >> OFF);
  assign req_tag_c   = TAG_W'(ifu_addr >> (OFF + IDX_W));
  assign req_word_c  = (WOFF_W == 0) ? '0 : WRD_W'(ifu_addr >> 2);
  assign beat_word_c = WRD_W'(beat_q);
  assign hit_c       = valid_q[req_idx_c] && (tags_q[req_idx_c] == req_tag_c);
  assign accept_c    = ifu_req_valid && ifu_req_ready;

  // A beat is bad on a non-OKAY response, an overlong burst, or an early rlast.
  assign beat_fire_c = (state_q == R) && rvalid && !rst;
  assign beat_ok_c   = beat_q < CNT_W'(BLOCK_WORDS);
  assign beat_err_c  = (rresp != 2'b00) || !beat_ok_c ||
                       (rlast && (beat_q != CNT_W'(BLOCK_WORDS - 1)));
  assign fence_now_c = (state_q == RESP) && (fence_pend_q || fence_i);

  // Handshake and response outputs, forced to their idle values while reset is held.
  assign ifu_req_ready = !rst && (state_q == IDLE) && !fence_i;
  assign ifu_rsp_valid = !rst && (state_q == RESP);
  assign ifu_rsp_err   = !rst && (state_q == RESP) && err_q;
  assign ifu_rdata     = rst ? 32'd0 : rdata_q;
  assign arvalid       = !rst && (state_q == AR);
  assign rready        = !rst && (state_q == R);
  assign araddr        = rst ? 32'd0 : araddr_q;
  assign arlen         = 8'(BLOCK_WORDS - 1);
  assign arsize        = 3'b010;
  assign arburst       = 2'b01;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = hit_c ? RESP : AR;
      AR:   if (arready) state_d = R;
      R:    if (rvalid && rlast) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line data storage, filled beat by beat during a refill.
  always_ff @(posedge clk) begin
    if (beat_fire_c && beat_ok_c) data_q[idx_q][beat_word_c] <= rdata;
  end

  // Tag store, written when the last beat of a refill lands.
  always_ff @(posedge clk) begin
    if (beat_fire_c && rlast) tags_q[idx_q] <= tag_q;
  end

  // Valid bits, request latch, refill bookkeeping and deferred fence handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      word_q       <= '0;
      beat_q       <= '0;
      fence_pend_q <= 1'b0;
      araddr_q     <= 32'd0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fence_i) begin
            valid_q <= '0;
          end else if (accept_c) begin
            idx_q  <= req_idx_c;
            tag_q  <= req_tag_c;
            word_q <= req_word_c;
            beat_q <= '0;
            err_q  <= 1'b0;
            if (hit_c) rdata_q  <= data_q[req_idx_c][req_word_c];
            else       araddr_q <= ifu_addr & LINE_MASK;
          end
        end
        AR: begin
          fence_pend_q <= fence_pend_q | fence_i;
        end
        R: begin
          fence_pend_q <= fence_pend_q | fence_i;
          if (rvalid) begin
            if (beat_ok_c) beat_q <= beat_q + CNT_W'(1);
            if (beat_ok_c && (beat_q == CNT_W'(word_q))) rdata_q <= rdata;
            err_q <= err_q | beat_err_c;
            if (rlast) valid_q[idx_q] <= !(err_q || beat_err_c);
          end
        end
        RESP: begin
          if (fence_now_c) valid_q <= '0;
          fence_pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef YSYX_24110015_ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  // Free-running hit/miss counters, one count per accepted fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_q  <= 32'd0;
      perf_miss_q <= 32'd0;
    end else if (accept_c) begin
      if (hit_c) perf_hit_q  <= perf_hit_q + 32'd1;
      else       perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif

endmodule

// File: tb/tb_ysyx_24110015_icache.sv
// Bench for ysyx_24110015_icache: directed vector table, hand sequences for fence/reset,
// then randomized fetches scored against an arithmetic cache model.
module tb_ysyx_24110015_icache;

  localparam int unsigned SETS = 16;
  localparam int unsigned BW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic        fence_i;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
`ifdef YSYX_24110015_ICACHE_PERF_EN
  logic [31:0] perf_hit, perf_miss;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_24110015_icache #(.SETS(SETS), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .fence_i(fence_i),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
`ifdef YSYX_24110015_ICACHE_PERF_EN
    , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
  );

  typedef struct {
    bit          got;
    bit          rst_hit;
    bit          proto_bad;
    int          n_ar;
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [31:0] ar_a;
    logic [7:0]  ar_l;
    logic [2:0]  ar_sz;
    logic [1:0]  ar_bu;
  } res_t;

  typedef struct {
    logic [31:0] addr;
    int          bad_beat;
    int          nbeats;
    int          fence_beat;
    bit          exp_hit;
    bit          exp_err;
  } vec_t;

  // Backing memory contents seen through the AXI slave.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model: which line (by tag) is resident and valid at each index.
  bit          m_valid [SETS];
  logic [31:0] m_tag   [SETS];

  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a / (4 * BW)) % SETS;
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] a);
    return a / (4 * BW * SETS);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < int'(SETS); i++) m_valid[i] = 1'b0;
  endtask

  task automatic m_step(input logic [31:0] a, input bit hit, input bit err, input bit fenced);
    if (!hit) begin
      m_valid[m_idx(a)] = !err;
      m_tag[m_idx(a)]   = m_tagof(a);
    end
    if (fenced) m_clear();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_rst_outs(input string t, input logic exp_ready);
    chk({t, ".ready"},   32'(ifu_req_ready), 32'(exp_ready));
    chk({t, ".rspv"},    32'(ifu_rsp_valid), 32'd0);
    chk({t, ".rsperr"},  32'(ifu_rsp_err),   32'd0);
    chk({t, ".rdata"},   ifu_rdata,          32'd0);
    chk({t, ".arvalid"}, 32'(arvalid),       32'd0);
    chk({t, ".rready"},  32'(rready),        32'd0);
    chk({t, ".araddr"},  araddr,             32'd0);
  endtask

  // One fetch with an embedded AXI read slave; inputs change at negedge, outputs sampled 1ns later.
  task automatic fetch(input logic [31:0] a, input int bad_beat, input int nbeats,
                       input int fence_beat, input int rst_beat, input bit rnd,
                       output res_t r);
    bit          acc, in_r, ar_wait, fence_done;
    int          beat;
    logic [31:0] line;
    r = '{default: 0};
    acc = 0; in_r = 0; ar_wait = 0; fence_done = 0; beat = 0;
    line = a & ~32'(4 * BW - 1);
    ifu_addr = a;
    for (int cyc = 0; cyc < 300 && !r.got && !r.rst_hit; cyc++) begin
      @(negedge clk);
      ifu_req_valid = !acc;
      arready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      rvalid  = in_r && (beat < nbeats) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      rdata   = mem_word(line + 32'(4 * beat));
      rresp   = (beat == bad_beat) ? 2'b10 : 2'b00;
      rlast   = (beat == nbeats - 1);
      fence_i = in_r && (beat == fence_beat) && !fence_done;
      if (fence_i) fence_done = 1;
      if (rst_beat >= 0 && rvalid && beat == rst_beat) rst = 1'b1;
      #1;
      if (rst) begin
        r.rst_hit = 1;
      end else begin
        if (acc) r.lat++;
        if (ifu_rsp_valid) begin
          r.got = 1;
          r.rd  = ifu_rdata;
          r.er  = ifu_rsp_err;
        end
        if (arvalid && in_r) r.proto_bad = 1;
        if (rready && !in_r) r.proto_bad = 1;
        if (arvalid) begin
          if (ar_wait && araddr != r.ar_a) r.proto_bad = 1;
          r.ar_a = araddr; r.ar_l = arlen; r.ar_sz = arsize; r.ar_bu = arburst;
          ar_wait = !arready;
          if (arready) begin
            r.n_ar++;
            in_r = 1;
          end
        end
        if (rvalid && rready) begin
          beat++;
          if (rlast) in_r = 0;
        end
        if (ifu_req_valid && ifu_req_ready) acc = 1;
      end
    end
    ifu_req_valid = 0; rvalid = 0; rlast = 0; rresp = 2'b00; fence_i = 0; arready = 0;
  endtask

  task automatic check_fetch(input string nm, input logic [31:0] a, input res_t r,
                             input bit exp_hit, input bit exp_err);
    chk({nm, ".rsp"}, 32'(r.got), 32'd1);
    if (r.got) begin
      if (exp_hit) begin
        chk({nm, ".n_ar"}, 32'(r.n_ar), 32'd0);
        chk({nm, ".lat"},  32'(r.lat),  32'd1);
      end else begin
        chk({nm, ".n_ar"},    32'(r.n_ar),  32'd1);
        chk({nm, ".araddr"},  r.ar_a,       a & ~32'(4 * BW - 1));
        chk({nm, ".arlen"},   32'(r.ar_l),  32'(BW - 1));
        chk({nm, ".arsize"},  32'(r.ar_sz), 32'd2);
        chk({nm, ".arburst"}, 32'(r.ar_bu), 32'd1);
      end
      chk({nm, ".err"}, 32'(r.er), 32'(exp_err));
      if (!exp_err) chk({nm, ".rdata"}, r.rd, mem_word(a));
      chk({nm, ".proto"}, 32'(r.proto_bad), 32'd0);
    end
  endtask

  vec_t tbl [13];

  initial begin
    res_t r;
    rst = 1'b1; ifu_req_valid = 0; ifu_addr = 0; fence_i = 0; arready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    m_clear();

    // Power-on reset values.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_rst_outs("por", 1'b0);
    @(negedge clk); rst = 1'b0;

    // addr, bad_beat, nbeats, fence_beat, exp_hit, exp_err
    tbl[0]  = '{32'h3000_0004, -1, BW, -1, 1'b0, 1'b0};
    tbl[1]  = '{32'h3000_0008, -1, BW, -1, 1'b1, 1'b0};
    tbl[2]  = '{32'h3000_0100, -1, BW, -1, 1'b0, 1'b0};
    tbl[3]  = '{32'h3000_0000, -1, BW, -1, 1'b0, 1'b0};
    tbl[4]  = '{32'h3000_0040,  2, BW, -1, 1'b0, 1'b1};
    tbl[5]  = '{32'h3000_0040, -1, BW, -1, 1'b0, 1'b0};
    tbl[6]  = '{32'h3000_0044, -1, BW, -1, 1'b1, 1'b0};
    tbl[7]  = '{32'h3000_0080, -1, BW,  1, 1'b0, 1'b0};
    tbl[8]  = '{32'h3000_0080, -1, BW, -1, 1'b0, 1'b0};
    tbl[9]  = '{32'h3000_0044, -1, BW, -1, 1'b0, 1'b0};
    tbl[10] = '{32'h3000_00C4, -1,  2, -1, 1'b0, 1'b1};
    tbl[11] = '{32'h3000_00C4, -1, BW, -1, 1'b0, 1'b0};
    tbl[12] = '{32'h3000_00C8, -1, BW, -1, 1'b1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      fetch(tbl[i].addr, tbl[i].bad_beat, tbl[i].nbeats, tbl[i].fence_beat, -1, 1'b0, r);
      check_fetch($sformatf("vec%0d", i), tbl[i].addr, r, tbl[i].exp_hit, tbl[i].exp_err);
      m_step(tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_err,
             !tbl[i].exp_hit && tbl[i].fence_beat >= 0);
`ifdef YSYX_24110015_ICACHE_PERF_EN
      if (i == 1) begin
        chk("perf.hit",  perf_hit,  32'd1);
        chk("perf.miss", perf_miss, 32'd1);
      end
`endif
    end
    chk("vec0.beat1", mem_word(32'h3000_0004), tbl[0].addr ^ 32'h3000_0004 ^ mem_word(32'h3000_0004));

    // fence_i in IDLE beats a same-cycle request and invalidates everything.
    @(negedge clk);
    fence_i = 1; ifu_req_valid = 1; ifu_addr = 32'h3000_00C8;
    #1;
    chk("fence_idle.ready", 32'(ifu_req_ready), 32'd0);
    @(negedge clk);
    fence_i = 0; ifu_req_valid = 0;
    #1;
    chk("fence_idle.rspv",    32'(ifu_rsp_valid), 32'd0);
    chk("fence_idle.arvalid", 32'(arvalid),       32'd0);
    m_clear();
    fetch(32'h3000_00C8, -1, BW, -1, -1, 1'b0, r);
    check_fetch("fence_idle.refetch", 32'h3000_00C8, r, 1'b0, 1'b0);
    m_step(32'h3000_00C8, 1'b0, 1'b0, 1'b0);

    // Reset asserted while beat 1 is on the bus; leftover beats must be refused.
    fetch(32'h3000_0204, -1, BW, -1, 1, 1'b0, r);
    chk("rst_mid.seen", 32'(r.rst_hit), 32'd1);
    chk_rst_outs("rst_mid.during", 1'b0);
    @(negedge clk);
    rst = 1'b0; rvalid = 1; rdata = 32'hDEAD_BEEF; rlast = 0;
    #1;
    chk_rst_outs("rst_mid.after", 1'b1);
    @(negedge clk);
    rlast = 1;
    #1;
    chk("rst_mid.tail_rready", 32'(rready),        32'd0);
    chk("rst_mid.tail_rspv",   32'(ifu_rsp_valid), 32'd0);
    @(negedge clk);
    rvalid = 0; rlast = 0;
    m_clear();
    fetch(32'h3000_0204, -1, BW, -1, -1, 1'b0, r);
    check_fetch("rst_mid.refetch", 32'h3000_0204, r, 1'b0, 1'b0);
    m_step(32'h3000_0204, 1'b0, 1'b0, 1'b0);

    // Randomized fetches with bus stalls, errors, short bursts and fences.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int          bb, nb, fb;
      bit          hit, err;
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk); fence_i = 1;
        @(negedge clk); fence_i = 0;
        m_clear();
      end
      a  = 32'h3000_0000 + (32'($urandom_range(0, 255)) << 2);
      bb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, BW - 1)) : -1;
      nb = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, BW - 1)) : int'(BW);
      fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      hit = m_hit(a);
      err = !hit && ((nb != int'(BW)) || (bb >= 0 && bb < nb));
      fetch(a, bb, nb, fb, -1, 1'b1, r);
      check_fetch($sformatf("rnd%0d@%08h", n, a), a, r, hit, err);
      m_step(a, hit, err, !hit && fb >= 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
